// File: rtl/axi_pkg.sv
// Shared AXI-lite types for the memory responder.
// Response codes and the write/read FSM state encodings.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_responder_if.sv
// Single-beat AXI slave bus bundle.
// The master drives requests, the slave returns responses.
interface axi_lite_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import axi_pkg::*;

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  resp_t                   bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  resp_t                   rresp;
  logic                    rlast;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/axi_mem_array.sv
// Byte-enabled word RAM: one write port, one registered read port.
// A read and write to the same word on one edge returns the old data.
module axi_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int LANES      = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [LANES-1:0]      wstrb,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rclr ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// Single-beat AXI slave memory model with independent write and
// read FSMs, byte-strobed writes and OKAY/SLVERR/DECERR responses.
module axi_lite_mem_responder
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi_lite_mem_responder_if.slave  s_axi
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN =
    ADDR_WIDTH'(MEM_DEPTH * LANES);

  wr_state_t             wstate;
  logic                  aw_done;
  logic                  w_done;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  resp_t                 bresp_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      wstrb_q;
  logic                  wlast_q;

  rd_state_t             rstate;
  logic                  arready_q;
  logic                  rvalid_q;
  resp_t                 rresp_q;
  logic [DATA_WIDTH-1:0] rdata_w;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  have_aw;
  logic                  have_w;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [LANES-1:0]      w_strb;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] r_off;
  logic                  r_in;
  logic                  unused_prot;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  assign aw_hs   = s_axi.awvalid & awready_q;
  assign w_hs    = s_axi.wvalid & wready_q;
  assign ar_hs   = s_axi.arvalid & arready_q;
  assign have_aw = aw_done | aw_hs;
  assign have_w  = w_done | w_hs;
  assign commit  = (wstate == W_IDLE) & have_aw & have_w;

  // the half arriving on the commit edge is used straight from the bus
  assign w_addr = aw_hs ? s_axi.awaddr : awaddr_q;
  assign w_data = w_hs ? s_axi.wdata : wdata_q;
  assign w_strb = w_hs ? s_axi.wstrb : wstrb_q;
  assign w_last = w_hs ? s_axi.wlast : wlast_q;

  assign w_off  = w_addr - BASE_ADDR;
  assign w_in   = w_off < SPAN;
  assign mem_we = commit & w_in & w_last & ~ARESET;

  assign r_off  = s_axi.araddr - BASE_ADDR;
  assign r_in   = r_off < SPAN;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate    <= W_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      if (aw_hs) awaddr_q <= s_axi.awaddr;
      if (w_hs) begin
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
        wlast_q <= s_axi.wlast;
      end
      unique case (wstate)
        W_IDLE: begin
          if (commit) begin
            wstate    <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= !w_in   ? DECERR :
                         !w_last ? SLVERR : OKAY;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            aw_done   <= have_aw;
            w_done    <= have_w;
            awready_q <= ~have_aw;
            wready_q  <= ~have_w;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            wstate    <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate    <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate    <= R_DATA;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rresp_q   <= r_in ? OKAY : DECERR;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rstate    <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  axi_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (ACLK),
    .rst   (ARESET),
    .we    (mem_we),
    .wstrb (w_strb),
    .waddr (w_off[LSB +: IDX_W]),
    .wdata (w_data),
    .re    (ar_hs),
    .rclr  (~r_in),
    .raddr (r_off[LSB +: IDX_W]),
    .rdata (rdata_w)
  );

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_w;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rvalid_q;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Bench for axi_lite_mem_responder: directed scenarios plus random
// traffic checked against a word-array model of the address map.
module tb_axi_lite_mem_responder;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_mem_responder_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) bus ();

  axi_lite_mem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (256),
    .BASE_ADDR  (32'h0)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axi  (bus)
  );

  int vectors = 0;
  int errors  = 0;
  logic [31:0] model [256];

  function automatic logic [1:0] model_write(
    input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] s, input logic last);
    if (a >= 32'h400) return 2'b11;
    if (!last) return 2'b10;
    for (int i = 0; i < 4; i++)
      if (s[i]) model[a[9:2]][i*8 +: 8] = d[i*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a < 32'h400) ? model[a[9:2]] : 32'h0;
  endfunction

  function automatic logic [1:0] model_rresp(input logic [31:0] a);
    return (a < 32'h400) ? 2'b00 : 2'b11;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 1;
    bus.bready = 1;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
    bus.rready = 1;
  endtask

  task automatic send_aw(input logic [31:0] a, output bit ok);
    ok = 0;
    bus.awvalid = 1; bus.awaddr = a;
    for (int i = 0; i < 40; i++) begin
      if (bus.awready) begin ok = 1; tick(); break; end
      tick();
    end
    bus.awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s,
                        input logic last, output bit ok);
    ok = 0;
    bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wlast = last;
    for (int i = 0; i < 40; i++) begin
      if (bus.wready) begin ok = 1; tick(); break; end
      tick();
    end
    bus.wvalid = 0;
  endtask

  task automatic send_ar(input logic [31:0] a, output bit ok);
    ok = 0;
    bus.arvalid = 1; bus.araddr = a;
    for (int i = 0; i < 40; i++) begin
      if (bus.arready) begin ok = 1; tick(); break; end
      tick();
    end
    bus.arvalid = 0;
  endtask

  // skew > 0: W leads AW by skew cycles; skew < 0: AW leads
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic last,
                          input int skew, output logic [1:0] resp,
                          output bit lat_ok);
    bit ok1, ok2;
    ok1 = 0; ok2 = 0;
    bus.bready = 1;
    fork
      begin
        if (skew > 0) repeat (skew) tick();
        send_aw(a, ok1);
      end
      begin
        if (skew < 0) repeat (-skew) tick();
        send_w(d, s, last, ok2);
      end
    join
    lat_ok = ok1 && ok2 && (bus.bvalid === 1'b1);
    for (int i = 0; i < 20 && bus.bvalid !== 1'b1; i++) tick();
    resp = bus.bresp;
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output logic last,
                         output bit lat_ok);
    bit ok;
    bus.rready = 1;
    send_ar(a, ok);
    lat_ok = ok && (bus.rvalid === 1'b1);
    for (int i = 0; i < 20 && bus.rvalid !== 1'b1; i++) tick();
    d = bus.rdata; resp = bus.rresp; last = bus.rlast;
    tick();
  endtask

  task automatic test_reset();
    logic [4:0] flags;
    idle_bus();
    rst = 1;
    repeat (3) tick();
    flags = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid};
    vectors++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", flags);
    end
    vectors++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h/%h/%h want 0/0/0",
               bus.bresp, bus.rresp, bus.rdata);
    end
    rst = 0;
    tick();
    flags = {bus.awready, bus.wready, bus.arready, 2'b00};
    vectors++;
    if (flags !== 5'b11100) begin
      errors++;
      $display("FAIL ready_after_reset: got %b want 11100", flags);
    end
  endtask

  task automatic clear_mem();
    logic [1:0] r;
    bit l;
    for (int i = 0; i < 256; i++)
      do_write(32'(i * 4), 32'h0, 4'hF, 1'b1, 0, r, l);
  endtask

  task automatic test_same_cycle();
    logic [1:0] r, er;
    logic [31:0] d;
    logic rl;
    bit l;
    er = model_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 0, r, l);
    vectors++;
    if (r !== er || !l) begin
      errors++;
      $display("FAIL same_cycle_bresp: got %b lat %0d want %b lat 1",
               r, l, er);
    end
    do_read(32'h10, d, r, rl, l);
    vectors++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || rl !== 1'b1 || !l) begin
      errors++;
      $display("FAIL same_cycle_read: got %h/%b/%b lat %0d want deadbeef/00/1",
               d, r, rl, l);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] r, er;
    logic [31:0] d;
    logic rl;
    bit l;
    er = model_write(32'h10, 32'h11223344, 4'b0101, 1'b1);
    do_write(32'h10, 32'h11223344, 4'b0101, 1'b1, 3, r, l);
    vectors++;
    if (r !== er || !l) begin
      errors++;
      $display("FAIL w_first_bresp: got %b lat %0d want %b", r, l, er);
    end
    do_read(32'h10, d, r, rl, l);
    vectors++;
    if (d !== 32'hDE22BE44 || d !== model_rdata(32'h10) || !l) begin
      errors++;
      $display("FAIL w_first_read: got %h want de22be44", d);
    end
  endtask

  task automatic test_decerr();
    logic [1:0] r, er;
    logic [31:0] d;
    logic rl;
    bit l;
    er = model_write(32'h400, 32'hCAFEF00D, 4'hF, 1'b1);
    do_write(32'h400, 32'hCAFEF00D, 4'hF, 1'b1, 0, r, l);
    vectors++;
    if (r !== er || er !== 2'b11) begin
      errors++;
      $display("FAIL decerr_bresp: got %b want 11", r);
    end
    do_read(32'h400, d, r, rl, l);
    vectors++;
    if (d !== 32'h0 || r !== 2'b11 || rl !== 1'b1) begin
      errors++;
      $display("FAIL decerr_read: got %h/%b/%b want 0/11/1", d, r, rl);
    end
    do_read(32'h0, d, r, rl, l);
    vectors++;
    if (d !== model_rdata(32'h0) || r !== 2'b00) begin
      errors++;
      $display("FAIL decerr_no_alias: got %h want %h", d, model_rdata(32'h0));
    end
  endtask

  task automatic test_slverr();
    logic [1:0] r, er;
    logic [31:0] d;
    logic rl;
    bit l;
    er = model_write(32'h20, 32'h55AA55AA, 4'hF, 1'b0);
    do_write(32'h20, 32'h55AA55AA, 4'hF, 1'b0, -2, r, l);
    vectors++;
    if (r !== er || er !== 2'b10 || !l) begin
      errors++;
      $display("FAIL slverr_bresp: got %b want 10", r);
    end
    do_read(32'h20, d, r, rl, l);
    vectors++;
    if (d !== model_rdata(32'h20)) begin
      errors++;
      $display("FAIL slverr_unchanged: got %h want %h", d, model_rdata(32'h20));
    end
    do_read(32'h13, d, r, rl, l);
    vectors++;
    if (d !== model_rdata(32'h10) || r !== 2'b00) begin
      errors++;
      $display("FAIL unaligned_read: got %h want %h", d, model_rdata(32'h10));
    end
  endtask

  task automatic test_stall();
    logic [31:0] wd, ed;
    logic [1:0] er;
    bit ok1, ok2;
    wd = $urandom;
    er = model_write(32'h30, wd, 4'hF, 1'b1);
    ed = model_rdata(32'h30);
    bus.bready = 0;
    fork
      send_aw(32'h30, ok1);
      send_w(wd, 4'hF, 1'b1, ok2);
    join
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== er ||
          bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
        errors++;
        $display("FAIL b_stall_%0d: got v%b r%b aw%b w%b want v1 r%b aw0 w0",
                 i, bus.bvalid, bus.bresp, bus.awready, bus.wready, er);
      end
      tick();
    end
    bus.bready = 1;
    tick();
    vectors++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
      errors++;
      $display("FAIL b_release: got v%b aw%b want v0 aw1",
               bus.bvalid, bus.awready);
    end
    bus.rready = 0;
    send_ar(32'h30, ok1);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== ed ||
          bus.rresp !== 2'b00 || bus.arready !== 1'b0) begin
        errors++;
        $display("FAIL r_stall_%0d: got v%b d%h ar%b want v1 d%h ar0",
                 i, bus.rvalid, bus.rdata, bus.arready, ed);
      end
      tick();
    end
    bus.rready = 1;
    tick();
    vectors++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      errors++;
      $display("FAIL r_release: got v%b ar%b want v0 ar1",
               bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_collision();
    logic [31:0] old_d, new_d, d;
    logic [1:0] wr, rr, er;
    logic rl;
    bit wl, rlat;
    old_d = model_rdata(32'h40);
    new_d = $urandom;
    er = model_write(32'h40, new_d, 4'hF, 1'b1);
    fork
      do_write(32'h40, new_d, 4'hF, 1'b1, 0, wr, wl);
      do_read(32'h40, d, rr, rl, rlat);
    join
    vectors++;
    if (d !== old_d || wr !== er || !wl || !rlat) begin
      errors++;
      $display("FAIL collision: got rd %h bresp %b want rd %h bresp %b",
               d, wr, old_d, er);
    end
    do_read(32'h40, d, rr, rl, rlat);
    vectors++;
    if (d !== new_d) begin
      errors++;
      $display("FAIL collision_after: got %h want %h", d, new_d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, wd;
    logic [1:0] r, er;
    logic rl;
    bit ok1, ok2, l;
    logic [4:0] flags;
    wd = $urandom;
    er = model_write(32'h80, wd, 4'hF, 1'b1);
    bus.bready = 0;
    fork
      send_aw(32'h80, ok1);
      send_w(wd, 4'hF, 1'b1, ok2);
    join
    vectors++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== er) begin
      errors++;
      $display("FAIL pre_reset_b: got v%b r%b want v1 r%b",
               bus.bvalid, bus.bresp, er);
    end
    rst = 1;
    tick();
    flags = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid};
    vectors++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL reset_in_b: got %b want 00000", flags);
    end
    rst = 0;
    bus.bready = 1;
    tick();
    send_aw(32'h84, ok1);
    rst = 1;
    tick();
    flags = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid};
    vectors++;
    if (flags !== 5'b0) begin
      errors++;
      $display("FAIL reset_in_aw: got %b want 00000", flags);
    end
    rst = 0;
    tick();
    wd = $urandom;
    send_w(wd, 4'hF, 1'b1, ok2);
    repeat (3) tick();
    vectors++;
    if (bus.bvalid !== 1'b0 || !ok2) begin
      errors++;
      $display("FAIL dropped_aw: got bvalid %b want 0", bus.bvalid);
    end
    er = model_write(32'h88, wd, 4'hF, 1'b1);
    send_aw(32'h88, ok1);
    vectors++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== er || !ok1) begin
      errors++;
      $display("FAIL post_reset_write: got v%b r%b want v1 r%b",
               bus.bvalid, bus.bresp, er);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = 32'h80 + 32'(k * 4);
      do_read(a, d, r, rl, l);
      vectors++;
      if (d !== model_rdata(a) || r !== 2'b00 || !l) begin
        errors++;
        $display("FAIL post_reset_read_%h: got %h want %h",
                 a, d, model_rdata(a));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd;
    logic [3:0] s;
    logic last, rl;
    logic [1:0] r, er;
    bit l;
    int skew;
    for (int n = 0; n < 150; n++) begin
      a = $urandom_range(0, 32'h4FF);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom);
        last = ($urandom_range(0, 7) != 0);
        skew = $urandom_range(0, 6) - 3;
        er = model_write(a, d, s, last);
        do_write(a, d, s, last, skew, r, l);
        vectors++;
        if (r !== er || !l) begin
          errors++;
          $display("FAIL rand_write_%0d @%h: got %b lat %0d want %b",
                   n, a, r, l, er);
        end
      end else begin
        do_read(a, rd, r, rl, l);
        vectors++;
        if (rd !== model_rdata(a) || r !== model_rresp(a) ||
            rl !== 1'b1 || !l) begin
          errors++;
          $display("FAIL rand_read_%0d @%h: got %h/%b want %h/%b",
                   n, a, rd, r, model_rdata(a), model_rresp(a));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    test_reset();
    clear_mem();
    test_same_cycle();
    test_w_first();
    test_decerr();
    test_slverr();
    test_stall();
    test_collision();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
